// File: rtl/vault_pkg.sv
// Shared types and constants for the vault alarm controller.
package vault_pkg;

    typedef enum logic [2:0] {
        DISARMED,
        ARMED,
        ENTRY,
        ALARM,
        SILENCED
    } state_t;

    localparam int unsigned TRIP_CNT_W = 8;
    localparam logic [TRIP_CNT_W-1:0] TRIP_CNT_MAX = '1;

    function automatic logic [TRIP_CNT_W-1:0] sat_inc(input logic [TRIP_CNT_W-1:0] v);
        return (v == TRIP_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/door_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; purely combinational.
module door_prio_enc #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vault_alarm_ctrl.sv
// Vault alarm controller: arm/entry-grace/alarm/silence FSM with latched trip
// information and a saturating trip counter. All outputs come from flops.
module vault_alarm_ctrl
    import vault_pkg::*;
#(
    parameter int unsigned NDOORS    = 4,
    parameter int unsigned GRACE_CYC = 8,
    parameter int unsigned SIREN_CYC = 16,
    localparam int unsigned TW = $clog2(NDOORS) + 1
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [NDOORS-1:0]     door_open,
    input  logic                  business_hrs,
    input  logic                  arm_sw,
    input  logic                  ack,
    output logic                  siren,
    output logic                  armed,
    output logic                  pending,
    output logic                  latched,
    output logic                  arm_fault,
    output logic [TW-1:0]         trip_door,
    output logic [TRIP_CNT_W-1:0] trip_count
);

    localparam int unsigned IW      = (NDOORS > 1) ? $clog2(NDOORS) : 1;
    localparam int unsigned CNT_MAX = (GRACE_CYC > SIREN_CYC) ? GRACE_CYC : SIREN_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           trip_q, trip_d;
    logic [TRIP_CNT_W-1:0]   count_q, count_d;
    logic                    fault_q, fault_d;
    logic [NDOORS-1:0]       door_q;

    logic [IW-1:0]           open_idx, rise_idx;
    logic                    open_vld, rise_vld;

    door_prio_enc #(.N(NDOORS)) u_open_enc (
        .req_i   (door_open),
        .idx_o   (open_idx),
        .valid_o (open_vld)
    );

    door_prio_enc #(.N(NDOORS)) u_rise_enc (
        .req_i   (door_open & ~door_q),
        .idx_o   (rise_idx),
        .valid_o (rise_vld)
    );

    function automatic logic [TW-1:0] mk_trip(input logic [IW-1:0] idx);
        return TW'(idx) | (TW'(1) << (TW - 1));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trip_d  = trip_q;
        unique case (state_q)
            DISARMED: begin
                if (arm_sw && !open_vld) state_d = ARMED;
            end
            ARMED: begin
                if (!arm_sw) begin
                    state_d = DISARMED;
                end else if (open_vld) begin
                    trip_d = mk_trip(open_idx);
                    if (business_hrs) begin
                        state_d = ENTRY;
                        cnt_d   = CW'(GRACE_CYC - 1);
                    end else begin
                        state_d = ALARM;
                        cnt_d   = CW'(SIREN_CYC - 1);
                    end
                end
            end
            ENTRY: begin
                if (!arm_sw) begin
                    state_d = DISARMED;
                end else if (cnt_q == '0) begin
                    state_d = ALARM;
                    cnt_d   = CW'(SIREN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ALARM: begin
                if (ack && !arm_sw) begin
                    state_d = DISARMED;
                end else if (cnt_q == '0) begin
                    state_d = SILENCED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SILENCED: begin
                if (ack && !arm_sw) begin
                    state_d = DISARMED;
                end else if (rise_vld) begin
                    state_d = ALARM;
                    cnt_d   = CW'(SIREN_CYC - 1);
                    trip_d  = mk_trip(rise_idx);
                end
            end
            default: state_d = DISARMED;
        endcase

        count_d = (state_d == ALARM && state_q != ALARM) ? sat_inc(count_q) : count_q;
        fault_d = (state_q == DISARMED) && arm_sw && open_vld;
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
            trip_q  <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
            door_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trip_q  <= trip_d;
            count_q <= count_d;
            fault_q <= fault_d;
            door_q  <= door_open;
        end
    end

    assign siren      = (state_q == ALARM);
    assign armed      = (state_q == ARMED) || (state_q == ENTRY);
    assign pending    = (state_q == ENTRY);
    assign latched    = (state_q == ALARM) || (state_q == SILENCED);
    assign arm_fault  = fault_q;
    assign trip_door  = trip_q;
    assign trip_count = count_q;

endmodule

// File: tb/tb_vault_alarm_ctrl.sv
// Scenario bench for vault_alarm_ctrl: expected output snapshots are queued as
// stimulus is applied and compared one cycle later.
module tb_vault_alarm_ctrl;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [3:0] door_open;
    logic       business_hrs;
    logic       arm_sw;
    logic       ack;
    logic       siren, armed, pending, latched, arm_fault;
    logic [2:0] trip_door;
    logic [7:0] trip_count;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [15:0] ALL = 16'hFFFF;
    localparam logic [15:0] TC  = 16'h00FF;

    typedef struct {
        string       name;
        logic [15:0] mask;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        logic [3:0] door;
        bit         bh;
        bit         arm;
        bit         ack;
        exp_t       e;
    } step_t;

    exp_t sb[$];

    vault_alarm_ctrl #(
        .NDOORS    (4),
        .GRACE_CYC (8),
        .SIREN_CYC (16)
    ) dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .door_open    (door_open),
        .business_hrs (business_hrs),
        .arm_sw       (arm_sw),
        .ack          (ack),
        .siren        (siren),
        .armed        (armed),
        .pending      (pending),
        .latched      (latched),
        .arm_fault    (arm_fault),
        .trip_door    (trip_door),
        .trip_count   (trip_count)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [15:0] obs();
        return {siren, armed, pending, latched, arm_fault, trip_door, trip_count};
    endfunction

    function automatic logic [15:0] mk(bit s, bit a, bit p, bit l, bit f,
                                       logic [2:0] td, logic [7:0] tc);
        return {s, a, p, l, f, td, tc};
    endfunction

    function automatic step_t st(string n, logic [3:0] d, bit bh, bit arm, bit ak,
                                 logic [15:0] m, logic [15:0] v);
        step_t s;
        s.door = d;
        s.bh   = bh;
        s.arm  = arm;
        s.ack  = ak;
        s.e.name = n;
        s.e.mask = m;
        s.e.val  = v;
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk_2);
        #1;
    endtask

    task automatic drive(input step_t s);
        door_open    = s.door;
        business_hrs = s.bh;
        arm_sw       = s.arm;
        ack          = s.ack;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        drive(st("", 4'b0, 0, 0, 0, 0, 0));
        sb.push_back('{"reset_all_zero", ALL, 16'h0000});
        cyc();
        e = sb.pop_front();
        n_total++;
        if ((obs() & e.mask) !== (e.val & e.mask))
            $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
        else
            n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_out_of_hours();
        step_t q[$];
        exp_t  e;
        q.push_back(st("ooh_armed",  4'b0000, 0, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b000, 0)));
        q.push_back(st("ooh_trip",   4'b0100, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b110, 1)));
        q.push_back(st("ooh_disarm", 4'b0000, 0, 0, 1, ALL, mk(0, 0, 0, 0, 0, 3'b110, 1)));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].e);
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_entry_grace();
        step_t q[$];
        exp_t  e;
        q.push_back(st("eg_armed", 4'b0000, 1, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b110, 1)));
        q.push_back(st("eg_entry", 4'b0001, 1, 1, 0, ALL, mk(0, 1, 1, 0, 0, 3'b100, 1)));
        // Door closes straight away; grace must keep running.
        for (int i = 0; i < 7; i++)
            q.push_back(st("eg_pending", 4'b0000, 1, 1, 0, ALL, mk(0, 1, 1, 0, 0, 3'b100, 1)));
        q.push_back(st("eg_alarm", 4'b0000, 1, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b100, 2)));
        q.push_back(st("eg_ack",   4'b0000, 1, 0, 1, ALL, mk(0, 0, 0, 0, 0, 3'b100, 2)));
        q.push_back(st("eg2_armed", 4'b0000, 1, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b100, 2)));
        q.push_back(st("eg2_entry", 4'b0001, 1, 1, 0, ALL, mk(0, 1, 1, 0, 0, 3'b100, 2)));
        for (int i = 0; i < 7; i++)
            q.push_back(st("eg2_pending", 4'b0000, 1, 1, 0, ALL, mk(0, 1, 1, 0, 0, 3'b100, 2)));
        q.push_back(st("eg2_disarm_at_expiry", 4'b0000, 1, 0, 0, ALL,
                       mk(0, 0, 0, 0, 0, 3'b100, 2)));
        for (int i = 0; i < 3; i++)
            q.push_back(st("eg2_quiet", 4'b0000, 1, 0, 0, ALL, mk(0, 0, 0, 0, 0, 3'b100, 2)));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].e);
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_siren_timeout();
        step_t q[$];
        exp_t  e;
        q.push_back(st("st_armed", 4'b0000, 0, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b100, 2)));
        q.push_back(st("st_trip",  4'b0001, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b100, 3)));
        for (int i = 0; i < 15; i++)
            q.push_back(st("st_siren", 4'b0001, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b100, 3)));
        q.push_back(st("st_silenced", 4'b0001, 0, 1, 0, ALL, mk(0, 0, 0, 1, 0, 3'b100, 3)));
        q.push_back(st("st_silenced_hold", 4'b0001, 0, 1, 0, ALL,
                       mk(0, 0, 0, 1, 0, 3'b100, 3)));
        // Door 0 stays open (no edge); door 3 opening is the only rising edge.
        q.push_back(st("st_door3_edge", 4'b1001, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b111, 4)));
        q.push_back(st("st_ack", 4'b0000, 0, 0, 1, ALL, mk(0, 0, 0, 0, 0, 3'b111, 4)));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].e);
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_arm_fault();
        step_t q[$];
        exp_t  e;
        q.push_back(st("af_fault",  4'b1000, 0, 1, 0, ALL, mk(0, 0, 0, 0, 1, 3'b111, 4)));
        q.push_back(st("af_fault2", 4'b1000, 0, 1, 0, ALL, mk(0, 0, 0, 0, 1, 3'b111, 4)));
        q.push_back(st("af_armed",  4'b0000, 0, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b111, 4)));
        q.push_back(st("af_disarm", 4'b0000, 0, 0, 0, ALL, mk(0, 0, 0, 0, 0, 3'b111, 4)));
        q.push_back(st("af_ack_idle", 4'b0000, 0, 0, 1, ALL, mk(0, 0, 0, 0, 0, 3'b111, 4)));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].e);
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
        end
    endtask

    task automatic test_ack();
        step_t q[$];
        exp_t  e;
        q.push_back(st("ak_armed",   4'b0000, 0, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b111, 4)));
        q.push_back(st("ak_trip",    4'b0010, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b101, 5)));
        q.push_back(st("ak_ignored", 4'b0010, 0, 1, 1, ALL, mk(1, 0, 0, 1, 0, 3'b101, 5)));
        q.push_back(st("ak_ignored", 4'b0010, 0, 1, 1, ALL, mk(1, 0, 0, 1, 0, 3'b101, 5)));
        q.push_back(st("ak_disarm",  4'b0000, 0, 0, 1, ALL, mk(0, 0, 0, 0, 0, 3'b101, 5)));
        q.push_back(st("ak_rearm",   4'b0000, 0, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b101, 5)));
        q.push_back(st("ak_trip2",   4'b0010, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b101, 6)));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].e);
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
        end
        // Reset mid-siren, between clock edges.
        #2;
        reset = 1'b1;
        sb.push_back('{"ak_async_reset", ALL, 16'h0000});
        #1;
        e = sb.pop_front();
        n_total++;
        if ((obs() & e.mask) !== (e.val & e.mask))
            $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
        else
            n_pass++;
        drive(st("", 4'b0, 0, 0, 0, 0, 0));
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        int   model_tc = 0;
        for (int i = 0; i < 300; i++) begin
            drive(st("", 4'b0000, 0, 1, 0, 0, 0));
            cyc();
            model_tc = (model_tc < 255) ? model_tc + 1 : 255;
            drive(st("", 4'b0001, 0, 1, 0, 0, 0));
            sb.push_back('{"sat_trip_count", TC, {8'h00, 8'(model_tc)}});
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
            drive(st("", 4'b0000, 0, 0, 1, 0, 0));
            cyc();
        end
    endtask

    task automatic test_multi_door();
        step_t q[$];
        exp_t  e;
        q.push_back(st("md_armed", 4'b0000, 0, 1, 0, ALL, mk(0, 1, 0, 0, 0, 3'b100, 255)));
        q.push_back(st("md_lowest", 4'b1010, 0, 1, 0, ALL, mk(1, 0, 0, 1, 0, 3'b101, 255)));
        q.push_back(st("md_ack", 4'b0000, 0, 0, 1, ALL, mk(0, 0, 0, 0, 0, 3'b101, 255)));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].e);
            cyc();
            e = sb.pop_front();
            n_total++;
            if ((obs() & e.mask) !== (e.val & e.mask))
                $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val & e.mask);
            else
                n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_out_of_hours();
        test_entry_grace();
        test_siren_timeout();
        test_arm_fault();
        test_ack();
        test_saturation();
        test_multi_door();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
